// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel prescaler, h/v counters, SYNC_PIPE-delayed valid/hsync/vsync.
// Optional frame-rate scroll_tick is built only when VGA_SCROLL_TICK_EN is defined.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_PIPE  = 1,
    parameter int SCROLL_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_stb,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       scroll_tick
);

    localparam int            PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
    localparam logic [9:0]    H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0]    H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]    V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0]    V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]    V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [PW-1:0] pre_r, pre_next_s;
    logic          pix_stb_r, stb_next_s;
    logic [9:0]    h_cnt_r, v_cnt_r, h_next_s, v_next_s;
    logic          frame_start_r, fs_next_s;
    logic          raw_valid_s, raw_hs_s, raw_vs_s;

    // Next-state of prescaler and counters; strobes are precomputed so they register in their own cycle
    always_comb begin
        pre_next_s = pre_r;
        h_next_s   = h_cnt_r;
        v_next_s   = v_cnt_r;
        if (pre_r == PRE_LAST) begin
            pre_next_s = '0;
        end else begin
            pre_next_s = pre_r + PW'(1);
        end
        if (pix_stb_r) begin
            if (h_cnt_r == H_LAST) begin
                h_next_s = 10'd0;
                if (v_cnt_r == V_LAST) begin
                    v_next_s = 10'd0;
                end else begin
                    v_next_s = v_cnt_r + 10'd1;
                end
            end else begin
                h_next_s = h_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r;
            v_next_s = v_cnt_r;
        end
        stb_next_s  = (pre_next_s == PRE_LAST);
        fs_next_s   = stb_next_s && (h_next_s == H_LAST) && (v_next_s == V_LAST);
        raw_valid_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        raw_hs_s    = !((h_cnt_r >= H_SYNC_ON) && (h_cnt_r < H_SYNC_OFF));
        raw_vs_s    = !((v_cnt_r >= V_SYNC_ON) && (v_cnt_r < V_SYNC_OFF));
    end

    // Prescaler, pixel strobe, raster counters and frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r         <= '0;
            pix_stb_r     <= 1'b0;
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            frame_start_r <= 1'b0;
        end else begin
            pre_r         <= pre_next_s;
            pix_stb_r     <= stb_next_s;
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            frame_start_r <= fs_next_s;
        end
    end

    generate
        if (SYNC_PIPE == 0) begin : g_nopipe
            logic valid_r, hsync_r, vsync_r;

            // Zero-depth: registered copy of the raw flags, refreshed every clk
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= 1'b0;
                    hsync_r <= 1'b1;
                    vsync_r <= 1'b1;
                end else begin
                    valid_r <= raw_valid_s;
                    hsync_r <= raw_hs_s;
                    vsync_r <= raw_vs_s;
                end
            end
            assign valid = valid_r;
            assign hsync = hsync_r;
            assign vsync = vsync_r;
        end else begin : g_pipe
            logic [SYNC_PIPE-1:0] valid_pipe_r, hsync_pipe_r, vsync_pipe_r;

            // Delay line advancing once per pixel so it tracks pixel-memory read latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_pipe_r <= '0;
                    hsync_pipe_r <= '1;
                    vsync_pipe_r <= '1;
                end else if (pix_stb_r) begin
                    valid_pipe_r[0] <= raw_valid_s;
                    hsync_pipe_r[0] <= raw_hs_s;
                    vsync_pipe_r[0] <= raw_vs_s;
                    for (int i = 1; i < SYNC_PIPE; i++) begin
                        valid_pipe_r[i] <= valid_pipe_r[i-1];
                        hsync_pipe_r[i] <= hsync_pipe_r[i-1];
                        vsync_pipe_r[i] <= vsync_pipe_r[i-1];
                    end
                end
            end
            assign valid = valid_pipe_r[SYNC_PIPE-1];
            assign hsync = hsync_pipe_r[SYNC_PIPE-1];
            assign vsync = vsync_pipe_r[SYNC_PIPE-1];
        end
    endgenerate

`ifdef VGA_SCROLL_TICK_EN
    localparam logic [7:0] FRAME_LAST = 8'(SCROLL_DIV - 1);

    logic [7:0] frame_cnt_r, frame_next_s;
    logic       scroll_tick_r;

    // Frame counter steps on each frame pulse
    always_comb begin
        frame_next_s = frame_cnt_r;
        if (frame_start_r) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_next_s = 8'd0;
            end else begin
                frame_next_s = frame_cnt_r + 8'd1;
            end
        end else begin
            frame_next_s = frame_cnt_r;
        end
    end

    // Tick rides on the frame pulse that wraps the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r   <= 8'd0;
            scroll_tick_r <= 1'b0;
        end else begin
            frame_cnt_r   <= frame_next_s;
            scroll_tick_r <= fs_next_s && (frame_next_s == FRAME_LAST);
        end
    end
    assign scroll_tick = scroll_tick_r;
`else
    assign scroll_tick = 1'b0;
`endif

    assign pix_stb     = pix_stb_r;
    assign h_cnt       = h_cnt_r;
    assign v_cnt       = v_cnt_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (15x8 pixels, CLK_DIV=4),
// with three instances at SYNC_PIPE 1, 0 and 3.
module tb_vga_timing_gen;

    localparam int CD = 4;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLK = CD * FRAME_PIX;
`ifdef VGA_SCROLL_TICK_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic       m_stb, m_valid, m_hs, m_vs, m_fs, m_st;
    logic [9:0] m_h, m_v;
    logic       z_stb, z_valid, z_hs, z_vs, z_fs, z_st;
    logic [9:0] z_h, z_v;
    logic       t_stb, t_valid, t_hs, t_vs, t_fs, t_st;
    logic [9:0] t_h, t_v;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_PIPE(1), .SCROLL_DIV(2)) u_main (
        .clk(clk), .rst(rst), .pix_stb(m_stb), .h_cnt(m_h), .v_cnt(m_v), .valid(m_valid),
        .hsync(m_hs), .vsync(m_vs), .frame_start(m_fs), .scroll_tick(m_st));

    vga_timing_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_PIPE(0), .SCROLL_DIV(1)) u_pipe0 (
        .clk(clk), .rst(rst), .pix_stb(z_stb), .h_cnt(z_h), .v_cnt(z_v), .valid(z_valid),
        .hsync(z_hs), .vsync(z_vs), .frame_start(z_fs), .scroll_tick(z_st));

    vga_timing_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_PIPE(3), .SCROLL_DIV(1)) u_pipe3 (
        .clk(clk), .rst(rst), .pix_stb(t_stb), .h_cnt(t_h), .v_cnt(t_v), .valid(t_valid),
        .hsync(t_hs), .vsync(t_vs), .frame_start(t_fs), .scroll_tick(t_st));

    // {valid, hsync, vsync} for raster pixel index p counted from release
    function automatic logic [2:0] sync_bits(int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return {(h < HA) && (v < VA), !((h >= HA + HF) && (h < HA + HF + HS)),
                !((v >= VA + VF) && (v < VA + VF + VS))};
    endfunction

    // Expected outputs n clk edges after release for pipe depth d
    function automatic logic [2:0] exp_sync(int n, int d);
        int s;
        if (d == 0) begin
            if (n == 0) return 3'b011;
            return sync_bits((n - 1) / CD);
        end
        s = n / CD;
        if (s < d) return 3'b011;
        return sync_bits(s - d);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (m_stb !== 1'b0) begin fails++; $display("FAIL reset_pix_stb got %b want 0", m_stb); end
        tests++; if (m_h !== 10'd0) begin fails++; $display("FAIL reset_h_cnt got %0d want 0", m_h); end
        tests++; if (m_v !== 10'd0) begin fails++; $display("FAIL reset_v_cnt got %0d want 0", m_v); end
        tests++; if ({m_valid, m_hs, m_vs} !== 3'b011) begin fails++; $display("FAIL reset_sync got %b want 011", {m_valid, m_hs, m_vs}); end
        tests++; if (m_fs !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b want 0", m_fs); end
        tests++; if (m_st !== 1'b0) begin fails++; $display("FAIL reset_scroll_tick got %b want 0", m_st); end
        tests++; if ({z_valid, z_hs, z_vs} !== 3'b011) begin fails++; $display("FAIL reset_sync_p0 got %b want 011", {z_valid, z_hs, z_vs}); end
        tests++; if ({t_valid, t_hs, t_vs} !== 3'b011) begin fails++; $display("FAIL reset_sync_p3 got %b want 011", {t_valid, t_hs, t_vs}); end
    endtask

    task automatic test_prescaler();
        do_reset();
        for (int n = 1; n <= 12 * CD; n++) begin
            @(negedge clk);
            tests++;
            if (m_stb !== ((n % CD) == CD - 1)) begin
                fails++; $display("FAIL pix_stb n=%0d got %b want %b", n, m_stb, (n % CD) == CD - 1);
            end
        end
    endtask

    task automatic test_counters();
        int p;
        do_reset();
        for (int n = 1; n <= 2 * FRAME_CLK + 3 * CD; n++) begin
            @(negedge clk);
            p = n / CD;
            tests++;
            if (m_h !== 10'(p % HT)) begin
                fails++; $display("FAIL h_cnt n=%0d got %0d want %0d", n, m_h, p % HT);
            end
            tests++;
            if (m_v !== 10'((p / HT) % VT)) begin
                fails++; $display("FAIL v_cnt n=%0d got %0d want %0d", n, m_v, (p / HT) % VT);
            end
        end
    endtask

    task automatic test_sync_pipe1();
        int hs_low, vs_low, vld;
        logic [2:0] e;
        hs_low = 0; vs_low = 0; vld = 0;
        do_reset();
        for (int n = 1; n <= FRAME_CLK; n++) begin
            @(negedge clk);
            e = exp_sync(n, 1);
            tests++;
            if ({m_valid, m_hs, m_vs} !== e) begin
                fails++; $display("FAIL sync_p1 n=%0d got %b want %b", n, {m_valid, m_hs, m_vs}, e);
            end
            if ((n % CD) == CD - 1) begin
                hs_low += (m_hs == 1'b0) ? 1 : 0;
                vs_low += (m_vs == 1'b0) ? 1 : 0;
                vld    += (m_valid == 1'b1) ? 1 : 0;
            end
        end
        tests++; if (hs_low != HS * VT) begin fails++; $display("FAIL hsync_low_strobes got %0d want %0d", hs_low, HS * VT); end
        tests++; if (vs_low != VS * HT) begin fails++; $display("FAIL vsync_low_strobes got %0d want %0d", vs_low, VS * HT); end
        tests++; if (vld != HA * VA) begin fails++; $display("FAIL valid_strobes got %0d want %0d", vld, HA * VA); end
    endtask

    task automatic test_pipe_depths();
        logic [2:0] e0, e3;
        do_reset();
        for (int n = 1; n <= FRAME_CLK + 4 * CD; n++) begin
            @(negedge clk);
            e0 = exp_sync(n, 0);
            e3 = exp_sync(n, 3);
            tests++;
            if ({z_valid, z_hs, z_vs} !== e0) begin
                fails++; $display("FAIL sync_p0 n=%0d got %b want %b", n, {z_valid, z_hs, z_vs}, e0);
            end
            tests++;
            if ({t_valid, t_hs, t_vs} !== e3) begin
                fails++; $display("FAIL sync_p3 n=%0d got %b want %b", n, {t_valid, t_hs, t_vs}, e3);
            end
        end
    endtask

    task automatic test_frame_start();
        int p, last_fs, nfs;
        logic efs, ets;
        last_fs = -1; nfs = 0;
        do_reset();
        for (int n = 1; n <= 3 * FRAME_CLK; n++) begin
            @(negedge clk);
            p   = n / CD;
            efs = ((n % CD) == CD - 1) && ((p % FRAME_PIX) == FRAME_PIX - 1);
            ets = efs && SCROLL_EN && (((p / FRAME_PIX) + 1) % 2 == 0);
            tests++;
            if (m_fs !== efs) begin fails++; $display("FAIL frame_start n=%0d got %b want %b", n, m_fs, efs); end
            tests++;
            if (m_st !== ets) begin fails++; $display("FAIL scroll_tick n=%0d got %b want %b", n, m_st, ets); end
            if (m_fs === 1'b1) begin
                if (last_fs >= 0) begin
                    tests++;
                    if (n - last_fs != FRAME_CLK) begin
                        fails++; $display("FAIL frame_period got %0d want %0d", n - last_fs, FRAME_CLK);
                    end
                end
                last_fs = n;
                nfs++;
            end
        end
        tests++; if (nfs != 3) begin fails++; $display("FAIL frame_count got %0d want 3", nfs); end
    endtask

    task automatic test_mid_frame_reset();
        do_reset();
        repeat (CD * (2 * HT + 5)) @(negedge clk);
        tests++; if (m_h !== 10'd5) begin fails++; $display("FAIL mid_pre_h got %0d want 5", m_h); end
        tests++; if (m_v !== 10'd2) begin fails++; $display("FAIL mid_pre_v got %0d want 2", m_v); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({m_stb, m_h, m_v, m_fs, m_st} !== 23'd0) begin
            fails++; $display("FAIL mid_async_cnt got stb=%b h=%0d v=%0d fs=%b st=%b want all 0", m_stb, m_h, m_v, m_fs, m_st);
        end
        tests++;
        if ({m_valid, m_hs, m_vs, z_valid, z_hs, z_vs, t_valid, t_hs, t_vs} !== 9'b011011011) begin
            fails++; $display("FAIL mid_async_sync got %b want 011011011",
                {m_valid, m_hs, m_vs, z_valid, z_hs, z_vs, t_valid, t_hs, t_vs});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= CD + 1; n++) begin
            @(negedge clk);
            tests++;
            if (m_stb !== ((n % CD) == CD - 1)) begin
                fails++; $display("FAIL mid_release_stb n=%0d got %b want %b", n, m_stb, (n % CD) == CD - 1);
            end
            tests++;
            if (m_h !== ((n >= CD) ? 10'd1 : 10'd0)) begin
                fails++; $display("FAIL mid_release_h n=%0d got %0d", n, m_h);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_counters();
        test_sync_pipe1();
        test_pipe_depths();
        test_frame_start();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
